// File: rtl/pcie_tl_defs.sv
// Shared transaction-layer definitions for the VC egress scheduler.
// Contents:
//   NUM_VC         - number of virtual channels merged by the arbiter
//   VC_W           - width of a VC index
//   DATA_WIDTH_DEF - default word width of the VC / output FIFO buses
//   arb_state_e    - arbiter FSM encoding, also exported on the debug port
package pcie_tl_defs;

    localparam int NUM_VC         = 4;
    localparam int VC_W           = 2;
    localparam int DATA_WIDTH_DEF = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_STALL  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/vc_rr_next.sv
// Combinational next-VC finder.
// Searches start+1, start+2, start+3 and finally start itself (mod NUM_VC)
// for the first VC whose FIFO is not empty.
// Ports:
//   start     in  VC_W    index the search wraps around (searched last)
//   empty     in  NUM_VC  per-VC FIFO empty flags
//   next_vc   out VC_W    first non-empty VC found (start when none)
//   any_valid out 1       at least one VC is non-empty
// Passing start = NUM_VC-1 turns this into a fixed priority encoder with
// VC0 as the highest priority.
module vc_rr_next
    import pcie_tl_defs::*;
(
    input  logic [VC_W-1:0]   start,
    input  logic [NUM_VC-1:0] empty,
    output logic [VC_W-1:0]   next_vc,
    output logic              any_valid
);

    always_comb begin
        logic [VC_W-1:0] idx;
        next_vc   = start;
        any_valid = 1'b0;
        idx       = start;
        // Walk from the farthest offset down to the nearest so the closest
        // non-empty VC after start is the one that sticks.
        for (int i = NUM_VC; i >= 1; i--) begin
            idx = start + VC_W'(i);
            if (!empty[idx]) begin
                next_vc   = idx;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vc_rr_arbiter.sv
// Egress scheduler: merges four show-ahead VC FIFOs into one output FIFO
// using burst-limited round-robin, honouring the output almost_full.
//
// Optional build macro VC_STRICT_PRIORITY_EN: when defined, the burst limit
// is ignored and the grant is re-evaluated every ACTIVE cycle to the
// lowest-index non-empty VC (VC0 highest priority, starvation allowed).
//
// Ports:
//   clk              in   rising-edge clock
//   reset            in   asynchronous active-low reset
//   data_in_0..3     in   head word of VCk FIFO (valid while !empty_k)
//   empty_0..3       in   VCk FIFO empty
//   almost_full_out  in   output FIFO almost full
//   pop_0..3         out  pop VCk FIFO (combinational)
//   data_out         out  word to output FIFO (registered)
//   push_out         out  push output FIFO (registered)
//   state            out  FSM state (IDLE=0, ACTIVE=1, STALL=2)
//   grant            out  currently granted VC index
//
// Handshake: a VC word transfers on any edge where pop_k is high; pop_k is
// only raised when VCk is not empty (its valid) and the output FIFO is not
// almost full (its ready). The popped word appears on data_out with
// push_out high exactly one cycle later; the output FIFO must accept it.
module vc_rr_arbiter
    import pcie_tl_defs::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BURST_MAX  = 4,
    parameter int CNT_W      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in_0,
    input  logic [DATA_WIDTH-1:0] data_in_1,
    input  logic [DATA_WIDTH-1:0] data_in_2,
    input  logic [DATA_WIDTH-1:0] data_in_3,
    input  logic                  empty_0,
    input  logic                  empty_1,
    input  logic                  empty_2,
    input  logic                  empty_3,
    input  logic                  almost_full_out,
    output logic                  pop_0,
    output logic                  pop_1,
    output logic                  pop_2,
    output logic                  pop_3,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  push_out,
    output logic [1:0]            state,
    output logic [1:0]            grant
);

    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX - 1);

    arb_state_e              state_q;
    logic [VC_W-1:0]         grant_q;
    logic [CNT_W-1:0]        count_q;
    logic [NUM_VC-1:0]       empty_vec;
    logic [NUM_VC-1:0]       pop_vec;
    logic [DATA_WIDTH-1:0]   data_sel;
    logic [VC_W-1:0]         rot_vc;
    logic                    rot_any;

    assign empty_vec = {empty_3, empty_2, empty_1, empty_0};

`ifdef VC_STRICT_PRIORITY_EN
    // Start fixed at the last VC so the search begins at VC0.
    vc_rr_next u_next (
        .start     (VC_W'(NUM_VC - 1)),
        .empty     (empty_vec),
        .next_vc   (rot_vc),
        .any_valid (rot_any)
    );
`else
    vc_rr_next u_next (
        .start     (grant_q),
        .empty     (empty_vec),
        .next_vc   (rot_vc),
        .any_valid (rot_any)
    );
`endif

    // Pop only the granted VC, and only when it has a word and the output
    // FIFO can take one. Combinational on almost_full_out so a pop in the
    // cycle almost_full rises is still suppressed/allowed on its live value.
    always_comb begin
        pop_vec = '0;
        if (state_q == ST_ACTIVE && !almost_full_out && !empty_vec[grant_q]) begin
            pop_vec[grant_q] = 1'b1;
        end
    end

    always_comb begin
        case (grant_q)
            2'd0:    data_sel = data_in_0;
            2'd1:    data_sel = data_in_1;
            2'd2:    data_sel = data_in_2;
            default: data_sel = data_in_3;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            count_q  <= '0;
            push_out <= 1'b0;
            data_out <= '0;
        end else begin
            push_out <= |pop_vec;
            if (|pop_vec) begin
                data_out <= data_sel;
            end

            case (state_q)
                ST_IDLE: begin
                    if (rot_any) begin
                        if (almost_full_out) begin
                            state_q <= ST_STALL;
                        end else begin
                            state_q <= ST_ACTIVE;
                            grant_q <= rot_vc;
                            count_q <= '0;
                        end
                    end
                end

                ST_ACTIVE: begin
                    if (almost_full_out) begin
                        state_q <= ST_STALL;
`ifdef VC_STRICT_PRIORITY_EN
                    end else begin
                        // Re-pick the highest-priority VC every cycle.
                        state_q <= rot_any ? ST_ACTIVE : ST_IDLE;
                        if (rot_any) grant_q <= rot_vc;
                        count_q <= '0;
                    end
`else
                    end else if (empty_vec[grant_q] || count_q == BURST_LAST) begin
                        // Granted VC ran dry, or this pop ends its burst.
                        state_q <= rot_any ? ST_ACTIVE : ST_IDLE;
                        if (rot_any) grant_q <= rot_vc;
                        count_q <= '0;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
`endif
                end

                ST_STALL: begin
                    if (!almost_full_out) begin
                        if (!empty_vec[grant_q]) begin
                            // Resume the interrupted burst where it left off.
                            state_q <= ST_ACTIVE;
                        end else begin
                            state_q <= rot_any ? ST_ACTIVE : ST_IDLE;
                            if (rot_any) grant_q <= rot_vc;
                            count_q <= '0;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign pop_0 = pop_vec[0];
    assign pop_1 = pop_vec[1];
    assign pop_2 = pop_vec[2];
    assign pop_3 = pop_vec[3];
    assign state = state_q;
    assign grant = grant_q;

endmodule

// File: tb/tb_vc_rr_arbiter.sv
// Directed testbench for vc_rr_arbiter: models four show-ahead VC FIFOs,
// drives directed scenarios and checks outputs against hand-derived
// cycle timelines and expected push-order queues.
module tb_vc_rr_arbiter;

    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] data_in_0, data_in_1, data_in_2, data_in_3;
    logic          empty_0, empty_1, empty_2, empty_3;
    logic          almost_full_out;
    logic          pop_0, pop_1, pop_2, pop_3;
    logic [DW-1:0] data_out;
    logic          push_out;
    logic [1:0]    state;
    logic [1:0]    grant;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q0[$], q1[$], q2[$], q3[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_v;
    logic [DW-1:0] junk;
    logic [3:0]    pv;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    vc_rr_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .data_in_0       (data_in_0),
        .data_in_1       (data_in_1),
        .data_in_2       (data_in_2),
        .data_in_3       (data_in_3),
        .empty_0         (empty_0),
        .empty_1         (empty_1),
        .empty_2         (empty_2),
        .empty_3         (empty_3),
        .almost_full_out (almost_full_out),
        .pop_0           (pop_0),
        .pop_1           (pop_1),
        .pop_2           (pop_2),
        .pop_3           (pop_3),
        .data_out        (data_out),
        .push_out        (push_out),
        .state           (state),
        .grant           (grant)
    );

    // ---------------- driver tasks ----------------
    task automatic update_inputs();
        empty_0 = (q0.size() == 0); data_in_0 = '0; if (q0.size() > 0) data_in_0 = q0[0];
        empty_1 = (q1.size() == 0); data_in_1 = '0; if (q1.size() > 0) data_in_1 = q1[0];
        empty_2 = (q2.size() == 0); data_in_2 = '0; if (q2.size() > 0) data_in_2 = q2[0];
        empty_3 = (q3.size() == 0); data_in_3 = '0; if (q3.size() > 0) data_in_3 = q3[0];
    endtask

    // One clock: capture the pops the DUT presents before the edge, then
    // retire those words from the VC FIFO models just after the edge.
    task automatic tick();
        @(negedge clk);
        pv = {pop_3, pop_2, pop_1, pop_0};
        @(posedge clk);
        #1;
        if (pv[0] && q0.size() > 0) junk = q0.pop_front();
        if (pv[1] && q1.size() > 0) junk = q1.pop_front();
        if (pv[2] && q2.size() > 0) junk = q2.pop_front();
        if (pv[3] && q3.size() > 0) junk = q3.pop_front();
        update_inputs();
        #1;
    endtask

    task automatic clear_all();
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        exp_q.delete();
        almost_full_out = 1'b0;
        update_inputs();
    endtask

    task automatic apply_reset();
        clear_all();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        clear_all();
        #2;
        reset = 1'b0;
        #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++; if (grant !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d want 0", grant); end
        checks++; if (push_out !== 1'b0) begin errors++; $display("FAIL reset_push: got %b want 0", push_out); end
        checks++; if (data_out !== 12'h000) begin errors++; $display("FAIL reset_data: got %h want 000", data_out); end
        checks++; if ({pop_3, pop_2, pop_1, pop_0} !== 4'b0000) begin errors++; $display("FAIL reset_pops: got %b want 0000", {pop_3, pop_2, pop_1, pop_0}); end
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        tick();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_idle_empty: got %0d want 0", state); end
    endtask

    task automatic test_fairness();
        apply_reset();
        for (int i = 0; i < 8; i++) q0.push_back(12'h0A0 + 12'(i));
        update_inputs();
        #1;
        for (int i = 0; i < 4; i++) exp_q.push_back(12'h0A0 + 12'(i));
        for (int i = 0; i < 4; i++) exp_q.push_back(12'h2A0 + 12'(i));
        for (int i = 4; i < 8; i++) exp_q.push_back(12'h0A0 + 12'(i));
        for (int i = 4; i < 8; i++) exp_q.push_back(12'h2A0 + 12'(i));
        for (int t = 1; t <= 19; t++) begin
            tick();
            if (t == 1) begin
                for (int i = 0; i < 8; i++) q2.push_back(12'h2A0 + 12'(i));
                update_inputs();
                #1;
                checks++; if (grant !== 2'd0) begin errors++; $display("FAIL fair_first_grant: got %0d want 0", grant); end
            end
            checks++;
            if (push_out !== (t >= 2 && t <= 17)) begin
                errors++; $display("FAIL fair_push t=%0d: got %b want %b", t, push_out, (t >= 2 && t <= 17));
            end
            if (push_out === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL fair_extra: data_out=%h pushed, want none", data_out);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (data_out !== exp_v) begin errors++; $display("FAIL fair_data: got %h want %h", data_out, exp_v); end
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fair_missing: %0d words not pushed, want 0", exp_q.size()); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL fair_end_state: got %0d want 0", state); end
    endtask

    task automatic test_backpressure();
        logic want_push;
        apply_reset();
        for (int i = 0; i < 6; i++) q3.push_back(12'h3B0 + 12'(i));
        q0.push_back(12'h0B0);
        q0.push_back(12'h0B1);
        update_inputs();
        #1;
        exp_q = '{12'h3B0, 12'h3B1, 12'h3B2, 12'h3B3, 12'h0B0, 12'h0B1, 12'h3B4, 12'h3B5};
        for (int t = 1; t <= 18; t++) begin
            tick();
            want_push = (t == 2 || t == 3 || (t >= 10 && t <= 13) || t == 15 || t == 16);
            checks++;
            if (push_out !== want_push) begin errors++; $display("FAIL bp_push t=%0d: got %b want %b", t, push_out, want_push); end
            if (push_out === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_extra: data_out=%h pushed, want none", data_out);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (data_out !== exp_v) begin errors++; $display("FAIL bp_data: got %h want %h", data_out, exp_v); end
                end
            end
            if (t == 1) begin
                checks++; if (grant !== 2'd3) begin errors++; $display("FAIL bp_grant: got %0d want 3", grant); end
            end
            if (t == 3) begin
                almost_full_out = 1'b1;
                #1;
                checks++; if (pop_3 !== 1'b0) begin errors++; $display("FAIL bp_pop_af_rise: got %b want 0", pop_3); end
            end
            if (t >= 4 && t <= 8) begin
                checks++; if (state !== 2'd2) begin errors++; $display("FAIL bp_state t=%0d: got %0d want 2", t, state); end
                checks++; if (pop_3 !== 1'b0) begin errors++; $display("FAIL bp_pop t=%0d: got %b want 0", t, pop_3); end
                checks++; if (grant !== 2'd3) begin errors++; $display("FAIL bp_hold_grant t=%0d: got %0d want 3", t, grant); end
            end
            if (t == 8) begin
                almost_full_out = 1'b0;
                #1;
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_missing: %0d words not pushed, want 0", exp_q.size()); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL bp_end_state: got %0d want 0", state); end
    endtask

    task automatic test_single_vc();
        apply_reset();
        for (int i = 0; i < 10; i++) q1.push_back(12'h1C0 + 12'(i));
        update_inputs();
        #1;
        for (int i = 0; i < 10; i++) exp_q.push_back(12'h1C0 + 12'(i));
        for (int t = 1; t <= 12; t++) begin
            tick();
            checks++;
            if (push_out !== (t >= 2 && t <= 11)) begin errors++; $display("FAIL single_push t=%0d: got %b want %b", t, push_out, (t >= 2 && t <= 11)); end
            checks++;
            if (pop_1 !== (t <= 10)) begin errors++; $display("FAIL single_pop t=%0d: got %b want %b", t, pop_1, (t <= 10)); end
            if (push_out === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL single_extra: data_out=%h pushed, want none", data_out);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (data_out !== exp_v) begin errors++; $display("FAIL single_data: got %h want %h", data_out, exp_v); end
                end
            end
        end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL single_end_state: got %0d want 0", state); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_missing: %0d words not pushed, want 0", exp_q.size()); end
    endtask

    task automatic test_simultaneous();
        logic want_push;
        apply_reset();
        q0.push_back(12'h0D0);
        q0.push_back(12'h0D1);
        update_inputs();
        #1;
        exp_q = '{12'h0D0, 12'h0D1, 12'h3D0, 12'h3D1};
        for (int t = 1; t <= 7; t++) begin
            tick();
            if (t == 3) begin
                q3.push_back(12'h3D0);
                q3.push_back(12'h3D1);
                update_inputs();
                #1;
                checks++; if ({pop_3, pop_2, pop_1, pop_0} !== 4'b0000) begin errors++; $display("FAIL sim_no_pop: got %b want 0000", {pop_3, pop_2, pop_1, pop_0}); end
            end
            checks++;
            if (({pop_3, pop_2, pop_1, pop_0} & {empty_3, empty_2, empty_1, empty_0}) !== 4'b0000) begin
                errors++; $display("FAIL sim_pop_empty t=%0d: got %b want 0000", t, {pop_3, pop_2, pop_1, pop_0} & {empty_3, empty_2, empty_1, empty_0});
            end
            want_push = (t == 2 || t == 3 || t == 5 || t == 6);
            checks++;
            if (push_out !== want_push) begin errors++; $display("FAIL sim_push t=%0d: got %b want %b", t, push_out, want_push); end
            if (push_out === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL sim_extra: data_out=%h pushed, want none", data_out);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (data_out !== exp_v) begin errors++; $display("FAIL sim_data: got %h want %h", data_out, exp_v); end
                end
            end
            if (t == 4) begin
                checks++; if (grant !== 2'd3) begin errors++; $display("FAIL sim_grant: got %0d want 3", grant); end
            end
        end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL sim_end_state: got %0d want 0", state); end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        for (int i = 0; i < 6; i++) q1.push_back(12'h1E0 + 12'(i));
        update_inputs();
        #1;
        tick();
        tick();
        checks++; if (push_out !== 1'b1 || data_out !== 12'h1E0) begin errors++; $display("FAIL rmb_first: got push=%b data=%h want push=1 data=1e0", push_out, data_out); end
        tick();
        reset = 1'b0;
        #1;
        checks++; if (push_out !== 1'b0) begin errors++; $display("FAIL rmb_push: got %b want 0", push_out); end
        checks++; if (pop_1 !== 1'b0) begin errors++; $display("FAIL rmb_pop1: got %b want 0", pop_1); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL rmb_state: got %0d want 0", state); end
        checks++; if (grant !== 2'd0) begin errors++; $display("FAIL rmb_grant: got %0d want 0", grant); end
        tick();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL rmb_held: got %0d want 0", state); end
        reset = 1'b1;
        #1;
        exp_q = '{12'h1E2, 12'h1E3, 12'h1E4, 12'h1E5};
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (t == 1) begin
                checks++; if (grant !== 2'd1 || state !== 2'd1) begin errors++; $display("FAIL rmb_restart: got grant=%0d state=%0d want grant=1 state=1", grant, state); end
            end
            checks++;
            if (push_out !== (t >= 2 && t <= 5)) begin errors++; $display("FAIL rmb_push_after t=%0d: got %b want %b", t, push_out, (t >= 2 && t <= 5)); end
            if (push_out === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rmb_extra: data_out=%h pushed, want none", data_out);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (data_out !== exp_v) begin errors++; $display("FAIL rmb_data: got %h want %h", data_out, exp_v); end
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rmb_missing: %0d words not pushed, want 0", exp_q.size()); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL rmb_end_state: got %0d want 0", state); end
    endtask

`ifdef VC_STRICT_PRIORITY_EN
    task automatic test_strict_priority();
        logic want_push;
        apply_reset();
        for (int i = 0; i < 3; i++) q0.push_back(12'h0F0 + 12'(i));
        for (int i = 0; i < 3; i++) q1.push_back(12'h1F0 + 12'(i));
        update_inputs();
        #1;
        exp_q = '{12'h0F0, 12'h0F1, 12'h0F2, 12'h1F0, 12'h1F1, 12'h1F2};
        for (int t = 1; t <= 9; t++) begin
            tick();
            if (t == 1) begin
                checks++; if (grant !== 2'd0) begin errors++; $display("FAIL prio_grant: got %0d want 0", grant); end
            end
            want_push = ((t >= 2 && t <= 4) || (t >= 6 && t <= 8));
            checks++;
            if (push_out !== want_push) begin errors++; $display("FAIL prio_push t=%0d: got %b want %b", t, push_out, want_push); end
            if (push_out === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL prio_extra: data_out=%h pushed, want none", data_out);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (data_out !== exp_v) begin errors++; $display("FAIL prio_data: got %h want %h", data_out, exp_v); end
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL prio_missing: %0d words not pushed, want 0", exp_q.size()); end
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
`ifdef VC_STRICT_PRIORITY_EN
        test_strict_priority();
`else
        test_fairness();
        test_backpressure();
        test_single_vc();
        test_simultaneous();
        test_reset_mid_burst();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
